// File: rtl/avalon_gpio_ctrl.sv
// Avalon-MM GPIO slave: per-bit direction, debounced synchronised inputs,
// atomic set/clear of outputs and maskable edge-capture interrupt.
module avalon_gpio_ctrl #(
  parameter int unsigned      WIDTH           = 10,
  parameter int unsigned      DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("avalon_gpio_ctrl: WIDTH must be in 1..32");
  end

  logic [WIDTH-1:0] r_s1, r_s2, r_stable, r_stable_q;
  logic [WIDTH-1:0] r_out, r_dir, r_mask, r_cap, r_mode;
  logic             r_irq;
  logic [31:0]      r_rdata;

  logic [WIDTH-1:0] w_wdata, w_clr, w_rise, w_fall, w_evt, w_rd_w;
  logic [31:0]      w_rd;

  assign w_wdata = avs_writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^avs_writedata[31:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= gpio_in;
      r_s2 <= r_s1;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_stable <= '0;
      else          r_stable <= r_s2;
    end
  end else begin : g_debounce
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] r_cnt [WIDTH];

    // Any return of s2 to the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_stable <= '0;
        for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (r_s2[i] == r_stable[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] == CntLast) begin
            r_stable[i] <= r_s2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CntW'(1);
          end
        end
      end
    end
  end

  assign w_rise = r_stable & ~r_stable_q;
  assign w_fall = ~r_stable & r_stable_q;
  assign w_evt  = (w_rise & ~r_mode) | (w_fall & r_mode);
  assign w_clr  = (avs_write && avs_address == 3'd4) ? w_wdata : '0;

  always_comb begin
    w_rd_w = '0;
    case (avs_address)
      3'd0:    w_rd_w = r_stable;
      3'd1:    w_rd_w = r_out;
      3'd2:    w_rd_w = r_dir;
      3'd3:    w_rd_w = r_mask;
      3'd4:    w_rd_w = r_cap;
      3'd5:    w_rd_w = r_mode;
      default: w_rd_w = '0;
    endcase
    w_rd = '0;
    w_rd[WIDTH-1:0] = w_rd_w;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_q <= '0;
      r_out      <= RESET_OUT;
      r_dir      <= '0;
      r_mask     <= '0;
      r_mode     <= '0;
      r_cap      <= '0;
      r_irq      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_stable_q <= r_stable;
      if (avs_write) begin
        case (avs_address)
          3'd1:    r_out  <= w_wdata;
          3'd2:    r_dir  <= w_wdata;
          3'd3:    r_mask <= w_wdata;
          3'd5:    r_mode <= w_wdata;
          3'd6:    r_out  <= r_out | w_wdata;
          3'd7:    r_out  <= r_out & ~w_wdata;
          default: ;
        endcase
      end
      // A new edge wins over a same-cycle W1C of that bit.
      r_cap <= (r_cap & ~w_clr) | w_evt;
      r_irq <= |(r_cap & r_mask);
      if (avs_read) r_rdata <= w_rd;
    end
  end

  assign avs_readdata = r_rdata;
  assign gpio_out     = r_out;
  assign gpio_oe      = r_dir;
  assign irq          = r_irq;

endmodule

// File: tb/tb_avalon_gpio_ctrl.sv
// Directed bench for avalon_gpio_ctrl (WIDTH=10, DEBOUNCE_CYCLES=16).
module tb_avalon_gpio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic [9:0]  gpio_in, gpio_out, gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_gpio_ctrl #(
    .WIDTH          (10),
    .DEBOUNCE_CYCLES(16),
    .RESET_OUT      (10'h000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .gpio_oe      (gpio_oe),
    .irq          (irq)
  );

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    #12;
    checks++; if (gpio_out !== 10'h000) begin errors++; $display("FAIL rst_gpio_out: got %h want 000", gpio_out); end
    checks++; if (gpio_oe !== 10'h000) begin errors++; $display("FAIL rst_gpio_oe: got %h want 000", gpio_oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h want 0", avs_readdata); end
    @(negedge clk); reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_readback[%0d]: got %h want 0", a, rd); end
    end
  endtask

  task automatic test_outputs();
    logic [31:0] rd;
    bus_write(3'd1, 32'hFFFF_F2A5);
    checks++; if (gpio_out !== 10'h2A5) begin errors++; $display("FAIL out_data: got %h want 2a5", gpio_out); end
    bus_read(3'd1, rd);
    checks++; if (rd !== 32'h2A5) begin errors++; $display("FAIL out_readback: got %h want 2a5", rd); end
    bus_write(3'd2, 32'h3FF);
    checks++; if (gpio_oe !== 10'h3FF) begin errors++; $display("FAIL out_dir: got %h want 3ff", gpio_oe); end
    bus_write(3'd6, 32'h00F);
    checks++; if (gpio_out !== 10'h2AF) begin errors++; $display("FAIL out_set: got %h want 2af", gpio_out); end
    bus_write(3'd7, 32'h0A0);
    checks++; if (gpio_out !== 10'h20F) begin errors++; $display("FAIL out_clr: got %h want 20f", gpio_out); end
    bus_read(3'd2, rd);
    checks++; if (rd !== 32'h3FF) begin errors++; $display("FAIL out_dir_rd: got %h want 3ff", rd); end
  endtask

  task automatic test_debounce();
    logic [31:0] rd;
    @(negedge clk); gpio_in[3] = 1'b1;
    wait_cycles(10);
    gpio_in[3] = 1'b0;
    wait_cycles(30);
    bus_read(3'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL glitch_data_in: got %h want 0", rd); end
    bus_read(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL glitch_edge_cap: got %h want 0", rd); end
    // Change lands before edge 1; stable must flip exactly at edge 18.
    @(negedge clk); gpio_in[3] = 1'b1;
    wait_cycles(17);
    avs_address = 3'd0; avs_read = 1'b1;
    @(negedge clk);
    checks++; if (avs_readdata[3] !== 1'b0) begin errors++; $display("FAIL db_edge17: got %b want 0", avs_readdata[3]); end
    @(negedge clk);
    checks++; if (avs_readdata[3] !== 1'b1) begin errors++; $display("FAIL db_edge18: got %b want 1", avs_readdata[3]); end
    avs_read = 1'b0;
    wait_cycles(5);
    bus_read(3'd4, rd);
    checks++; if (rd !== 32'h008) begin errors++; $display("FAIL db_edge_cap: got %h want 008", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    bus_write(3'd4, 32'h008);
    bus_read(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_w1c_init: got %h want 0", rd); end
    bus_write(3'd3, 32'h008);
    wait_cycles(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
    gpio_in[3] = 1'b0;
    wait_cycles(25);
    bus_read(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_fall_ignored: got %h want 0", rd); end
    gpio_in[3] = 1'b1;
    wait_cycles(25);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b want 1", irq); end
    @(negedge clk); avs_address = 3'd4; avs_writedata = 32'h008; avs_write = 1'b1;
    @(negedge clk); avs_write = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_clear_lag: got %b want 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert: got %b want 0", irq); end
    // W1C lands on the same edge as a fresh rising capture.
    gpio_in[3] = 1'b0;
    wait_cycles(25);
    @(negedge clk); gpio_in[3] = 1'b1;
    wait_cycles(18);
    avs_address = 3'd4; avs_writedata = 32'h008; avs_write = 1'b1;
    @(negedge clk); avs_write = 1'b0;
    bus_read(3'd4, rd);
    checks++; if (rd !== 32'h008) begin errors++; $display("FAIL irq_set_priority: got %h want 008", rd); end
    bus_write(3'd4, 32'h008);
    wait_cycles(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_final_clear: got %b want 0", irq); end
  endtask

  task automatic test_falling();
    logic [31:0] rd;
    bus_write(3'd5, 32'h001);
    bus_read(3'd5, rd);
    checks++; if (rd !== 32'h001) begin errors++; $display("FAIL fall_mode_rd: got %h want 001", rd); end
    gpio_in[0] = 1'b1;
    wait_cycles(25);
    bus_read(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fall_rise_ignored: got %h want 0", rd); end
    gpio_in[0] = 1'b0;
    wait_cycles(25);
    bus_read(3'd4, rd);
    checks++; if (rd !== 32'h001) begin errors++; $display("FAIL fall_capture: got %h want 001", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fall_masked_irq: got %b want 0", irq); end
    bus_write(3'd4, 32'h001);
    bus_read(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fall_w1c: got %h want 0", rd); end
  endtask

  task automatic test_bus();
    logic [31:0] rd;
    bus_read(3'd6, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bus_rd6: got %h want 0", rd); end
    bus_read(3'd7, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bus_rd7: got %h want 0", rd); end
    @(negedge clk);
    avs_address = 3'd2; avs_writedata = 32'h155; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    checks++; if (avs_readdata !== 32'h3FF) begin errors++; $display("FAIL bus_rw_old: got %h want 3ff", avs_readdata); end
    checks++; if (gpio_oe !== 10'h155) begin errors++; $display("FAIL bus_rw_oe: got %h want 155", gpio_oe); end
    bus_read(3'd2, rd);
    checks++; if (rd !== 32'h155) begin errors++; $display("FAIL bus_rd_new: got %h want 155", rd); end
    avs_address = 3'd1;
    wait_cycles(3);
    checks++; if (avs_readdata !== 32'h155) begin errors++; $display("FAIL bus_hold: got %h want 155", avs_readdata); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    gpio_in[3] = 1'b0;
    wait_cycles(25);
    gpio_in[3] = 1'b1;
    wait_cycles(25);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_pre_irq: got %b want 1", irq); end
    bus_read(3'd1, rd);
    checks++; if (rd !== 32'h20F) begin errors++; $display("FAIL mid_pre_out: got %h want 20f", rd); end
    @(negedge clk);
    gpio_in = 10'h000;
    avs_address = 3'd1; avs_writedata = 32'h3FF; avs_write = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (gpio_out !== 10'h000) begin errors++; $display("FAIL mid_gpio_out: got %h want 000", gpio_out); end
    checks++; if (gpio_oe !== 10'h000) begin errors++; $display("FAIL mid_gpio_oe: got %h want 000", gpio_oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b want 0", irq); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL mid_readdata: got %h want 0", avs_readdata); end
    wait_cycles(2);
    avs_write = 1'b0;
    reset_n = 1'b1;
    wait_cycles(30);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_post_irq: got %b want 0", irq); end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_readback[%0d]: got %h want 0", a, rd); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    gpio_in = '0;
    test_reset();
    test_outputs();
    test_debounce();
    test_irq();
    test_falling();
    test_bus();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
